mux16_scan_ctrl: RTL and testbench

Sequential scan controller that sits directly around the 16:1 data-flow mux (`mux16_1`). It drives the mux select lines `s0..s3` through all 16 channels in order and samples the mux output `out` on each channel after a programmable settle time. It assembles the 16 sampled bits into one result word, published with a start/busy/done handshake. Downstream logic reads all 16 mux inputs as a single word, with no need to sequence the selects itself.

---
 rtl/mux16_scan_if.sv | 26 ++
 rtl/mux16_scan_ctrl.sv | 126 ++++++++++++
 tb/tb_mux16_scan_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mux16_scan_if.sv
// Handshake and mux-facing signals of the 16-channel scan controller.
// The cont input exists only when MUX16_SCAN_CONT_EN is defined.
interface mux16_scan_if;
  logic        start;
  logic        sample_in;
  logic        s0;
  logic        s1;
  logic        s2;
  logic        s3;
  logic        busy;
  logic        done;
  logic [15:0] result;
`ifdef MUX16_SCAN_CONT_EN
  logic        cont;

  modport master (output start, sample_in, cont,
                  input  s0, s1, s2, s3, busy, done, result);
  modport slave  (input  start, sample_in, cont,
                  output s0, s1, s2, s3, busy, done, result);
`else
  modport master (output start, sample_in,
                  input  s0, s1, s2, s3, busy, done, result);
  modport slave  (input  start, sample_in,
                  output s0, s1, s2, s3, busy, done, result);
`endif
endinterface

// File: rtl/mux16_scan_ctrl.sv
// Steps a 16:1 mux through all channels, samples each after DWELL cycles and
// publishes the 16 samples as one word. Optional continuous mode: MUX16_SCAN_CONT_EN.
module mux16_scan_ctrl #(
  parameter int DWELL = 2,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mux16_scan_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A dwell of 0 is treated as 1 so the counter compare is always reachable.
  localparam int               DW_EFF   = (DWELL < 1) ? 1 : DWELL;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DW_EFF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q,  state_d;
  logic [3:0]       ch_q,     ch_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      result_q, result_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             cont_s;

`ifdef MUX16_SCAN_CONT_EN
  assign cont_s = bus.cont;
`else
  assign cont_s = 1'b0;
`endif

  // Next-state logic; ch_q doubles as the registered select value and is 0 outside SCAN.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ch_d  = 4'd0;
        cnt_d = {CNT_W{1'b0}};
        if (bus.start) begin
          state_d  = ST_SCAN;
          busy_d   = 1'b1;
          shadow_d = 16'h0000;
        end else begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
        end
      end
      ST_SCAN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = {CNT_W{1'b0}};
          shadow_d[ch_q] = bus.sample_in;
          if (ch_q == 4'd15) begin
            // Result and done are registered on the last sample edge so they appear in DONE.
            state_d  = ST_DONE;
            result_d = shadow_d;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            ch_d     = 4'd0;
          end else begin
            ch_d = ch_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DONE: begin
        ch_d  = 4'd0;
        cnt_d = {CNT_W{1'b0}};
        if (cont_s) begin
          state_d  = ST_SCAN;
          busy_d   = 1'b1;
          shadow_d = 16'h0000;
        end else begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        ch_d     = 4'd0;
        cnt_d    = {CNT_W{1'b0}};
        busy_d   = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ch_q     <= 4'd0;
      cnt_q    <= {CNT_W{1'b0}};
      shadow_q <= 16'h0000;
      result_q <= 16'h0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.s0     = ch_q[3];
  assign bus.s1     = ch_q[2];
  assign bus.s2     = ch_q[1];
  assign bus.s3     = ch_q[0];
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// Bench for mux16_scan_ctrl: one instance with DWELL=2, one with DWELL=1, each
// around a behavioural 16:1 mux; table vectors, hand sequences and random scans.
module tb_mux16_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_s [2];
  logic [15:0] mux_in  [2];
  logic [3:0]  sel_w   [2];
  logic        busy_w  [2];
  logic        done_w  [2];
  logic [15:0] res_w   [2];
  logic [15:0] res_exp [2];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  mux16_scan_if bus0 ();
  mux16_scan_if bus1 ();

  mux16_scan_ctrl #(.DWELL(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  mux16_scan_ctrl #(.DWELL(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  assign bus0.start     = start_s[0];
  assign bus1.start     = start_s[1];
  assign sel_w[0]       = {bus0.s0, bus0.s1, bus0.s2, bus0.s3};
  assign sel_w[1]       = {bus1.s0, bus1.s1, bus1.s2, bus1.s3};
  assign bus0.sample_in = mux_in[0][sel_w[0]];
  assign bus1.sample_in = mux_in[1][sel_w[1]];
  assign busy_w[0] = bus0.busy;
  assign busy_w[1] = bus1.busy;
  assign done_w[0] = bus0.done;
  assign done_w[1] = bus1.done;
  assign res_w[0]  = bus0.result;
  assign res_w[1]  = bus1.result;

`ifdef MUX16_SCAN_CONT_EN
  logic cont_s = 1'b0;
  assign bus0.cont = cont_s;
  assign bus1.cont = 1'b0;
`endif

  typedef struct {
    int          u;
    logic [15:0] data;
    int          rs;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // One full scan on unit u; expectations come from the timing rules:
  // after edge E0+t the select is t/dw, channel k is sampled at edge E0+(k+1)*dw,
  // done follows edge E0+16*dw. rs>0 re-pulses start before that edge index.
  task automatic run_scan(input int u, input logic [15:0] data, input bit rnd,
                          input int rs, output logic [15:0] got);
    int          dw;
    int          k;
    logic [15:0] exp_r;
    dw     = (u == 0) ? 2 : 1;
    exp_r  = 16'h0000;
    mux_in[u]  = data;
    start_s[u] = 1'b1;
    @(posedge clk);
    #1 start_s[u] = 1'b0;
    for (int t = 0; t <= 16 * dw; t++) begin
      chk("sel",  32'(sel_w[u]),  (t < 16 * dw) ? 32'(t / dw) : 32'd0);
      chk("busy", 32'(busy_w[u]), (t < 16 * dw) ? 32'd1 : 32'd0);
      chk("done", 32'(done_w[u]), (t == 16 * dw) ? 32'd1 : 32'd0);
      chk("result", 32'(res_w[u]), (t == 16 * dw) ? 32'(exp_r) : 32'(res_exp[u]));
      if (t < 16 * dw) begin
        if (rnd) mux_in[u] = 16'($urandom);
        if (((t + 1) % dw) == 0) begin
          k = (t + 1) / dw - 1;
          exp_r[k] = mux_in[u][k];
        end
        start_s[u] = (t + 1 == rs) ? 1'b1 : 1'b0;
        @(posedge clk);
        #1;
      end
    end
    start_s[u] = 1'b0;
    got        = res_w[u];
    res_exp[u] = exp_r;
    @(posedge clk);
    #1;
    chk("post_done", 32'(done_w[u]), 32'd0);
    chk("post_busy", 32'(busy_w[u]), 32'd0);
    chk("post_result", 32'(res_w[u]), 32'(exp_r));
  endtask

  initial begin
    logic [15:0] got;
    int          n;
    int          hits;

    vecs[0] = '{u: 0, data: 16'h5555, rs: 10, exp: 16'h5555};
    vecs[1] = '{u: 1, data: 16'h8000, rs: -1, exp: 16'h8000};
    vecs[2] = '{u: 0, data: 16'hFFFF, rs: -1, exp: 16'hFFFF};
    vecs[3] = '{u: 1, data: 16'h0000, rs: 5,  exp: 16'h0000};
    vecs[4] = '{u: 0, data: 16'hA5C3, rs: -1, exp: 16'hA5C3};
    vecs[5] = '{u: 1, data: 16'h0001, rs: -1, exp: 16'h0001};

    start_s[0] = 1'b0; start_s[1] = 1'b0;
    mux_in[0]  = 16'h0000; mux_in[1] = 16'h0000;
    res_exp[0] = 16'h0000; res_exp[1] = 16'h0000;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_sel",    32'(sel_w[u]),  32'd0);
      chk("rst_busy",   32'(busy_w[u]), 32'd0);
      chk("rst_done",   32'(done_w[u]), 32'd0);
      chk("rst_result", 32'(res_w[u]),  32'd0);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      run_scan(vecs[i].u, vecs[i].data, 1'b0, vecs[i].rs, got);
      chk("vec_result", 32'(got), 32'(vecs[i].exp));
    end

    // Start held high on the DWELL=1 unit: one IDLE cycle between scans.
    mux_in[1]  = 16'h00F0;
    start_s[1] = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!done_w[1] && n < 100);
    chk("b2b_first_latency", 32'(n), 32'd17);
    chk("b2b_first_result", 32'(res_w[1]), 32'h00F0);
    @(posedge clk);
    #1 chk("b2b_idle_gap", 32'(busy_w[1]), 32'd0);
    @(posedge clk);
    #1 chk("b2b_relaunch", 32'(busy_w[1]), 32'd1);
    start_s[1] = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!done_w[1] && n < 100);
    chk("b2b_second_latency", 32'(n), 32'd16);
    chk("b2b_second_result", 32'(res_w[1]), 32'h00F0);
    res_exp[1] = 16'h00F0;
    @(posedge clk);
    #1;

    // Reset in cycle 12 of a scan on top of a 5555 result.
    run_scan(0, 16'h5555, 1'b0, -1, got);
    start_s[0] = 1'b1;
    @(posedge clk);
    #1 start_s[0] = 1'b0;
    repeat (11) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sel",    32'(sel_w[0]),  32'd0);
    chk("mid_rst_busy",   32'(busy_w[0]), 32'd0);
    chk("mid_rst_done",   32'(done_w[0]), 32'd0);
    chk("mid_rst_result", 32'(res_w[0]),  32'd0);
    res_exp[0] = 16'h0000;
    res_exp[1] = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_scan(0, 16'h5555, 1'b0, -1, got);
    chk("after_rst_result", 32'(got), 32'h5555);

    // Random scans with inputs changing every cycle.
    for (int i = 0; i < 8; i++) begin
      run_scan(int'($urandom_range(0, 1)), 16'($urandom), 1'b1, -1, got);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

`ifdef MUX16_SCAN_CONT_EN
    mux_in[0]  = 16'h5555;
    cont_s     = 1'b1;
    start_s[0] = 1'b1;
    @(posedge clk);
    #1 start_s[0] = 1'b0;
    n = 1;
    hits = 0;
    while (hits < 3 && n < 200) begin
      if (done_w[0]) begin
        hits++;
        chk("cont_done_time", 32'(n), 32'(33 * hits));
        chk("cont_result", 32'(res_w[0]), (hits == 1) ? 32'h5555 : 32'h5554);
        if (hits == 1) mux_in[0][0] = 1'b0;
        if (hits == 2) cont_s = 1'b0;
      end
      if (hits < 3) begin
        @(posedge clk);
        #1 n++;
      end
    end
    chk("cont_done_count", 32'(hits), 32'd3);
    @(posedge clk);
    #1 chk("cont_stopped_busy", 32'(busy_w[0]), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
